seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit combinational ALU.
- Data width is set by WIDTH.
- Adds carry-in arithmetic, arithmetic shift right and unsigned multiply.
- Adds a full flag set (C, Z, N, V).
- Results are registered and returned through a start/done handshake.
- Sits between the register file and the writeback mux. The control unit issues one operation at a time and waits for done.

---
 rtl/seq_alu.sv | 200 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle parametrised ALU: single-cycle arithmetic/logic, bit-serial shifts
// and shift-and-add multiply, returned through a start/done handshake.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] D_hi,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam int               CW      = $clog2(WIDTH + 1);
    localparam int               MSB     = WIDTH - 1;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                           OP_OR  = 4'b0011, OP_SHL = 4'b0100, OP_SHR = 4'b0101,
                           OP_XOR = 4'b0110, OP_NOT = 4'b0111, OP_ADC = 4'b1000,
                           OP_SBC = 4'b1001, OP_ASR = 4'b1010, OP_MUL = 4'b1011;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t           state, state_next;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work_q;   // shift operand, or remaining multiplier bits
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [CW-1:0]    cnt_q;

    logic             accept, is_shift, go_shift, go_mul, last_step;
    logic [CW-1:0]    shamt;

    assign accept    = start && !busy;
    assign is_shift  = (S == OP_SHL) || (S == OP_SHR) || (S == OP_ASR);
    assign shamt     = (B < WIDTH_V) ? B[CW-1:0] : WIDTH_C;
    assign go_shift  = accept && is_shift && (shamt != '0);
    assign go_mul    = accept && (S == OP_MUL);
    assign last_step = (cnt_q == CW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (go_shift)    state_next = SHIFT;
                else if (go_mul) state_next = MUL;
            end
            SHIFT, MUL: if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb busy = (state != IDLE);

    logic [WIDTH-1:0] opb, alu_d;
    logic [WIDTH:0]   sum;
    logic             cy_in, alu_c, alu_v, alu_rsv;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        opb     = ((S == OP_SUB) || (S == OP_SBC)) ? ~B : B;
        cy_in   = (S == OP_SUB) ? 1'b1 : ((S == OP_ADC) || (S == OP_SBC)) ? Cin : 1'b0;
        sum     = {1'b0, A} + {1'b0, opb} + {{WIDTH{1'b0}}, cy_in};
        alu_d   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_rsv = 1'b0;
        case (S)
            OP_ADD, OP_ADC: begin
                alu_d = sum[MSB:0];
                alu_c = sum[WIDTH];
                alu_v = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB, OP_SBC: begin
                alu_d = sum[MSB:0];
                alu_c = sum[WIDTH];
                alu_v = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_AND: alu_d = A & B;
            OP_OR:  alu_d = A | B;
            OP_XOR: alu_d = A ^ B;
            OP_NOT: alu_d = ~A;
            OP_SHL, OP_SHR, OP_ASR: alu_d = A;  // only used for a zero shift count
            OP_MUL: alu_d = '0;
            default: alu_rsv = 1'b1;
        endcase
    end

    logic [WIDTH-1:0] sh_next, mul_hi, mul_lo;
    logic             sh_out;
    logic [WIDTH:0]   mul_sum;

    always_comb begin
        case (op_q)
            OP_SHL: begin
                sh_next = {work_q[MSB-1:0], 1'b0};
                sh_out  = work_q[MSB];
            end
            OP_SHR: begin
                sh_next = {1'b0, work_q[MSB:1]};
                sh_out  = work_q[0];
            end
            default: begin
                sh_next = {work_q[MSB], work_q[MSB:1]};
                sh_out  = work_q[0];
            end
        endcase
        mul_sum          = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        {mul_hi, mul_lo} = {mul_sum, work_q[MSB:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            D       <= '0;
            D_hi    <= '0;
            C       <= 1'b0;
            Z       <= 1'b0;
            N       <= 1'b0;
            V       <= 1'b0;
            op_q    <= '0;
            work_q  <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_q <= S;
                    if (go_shift) begin
                        work_q <= A;
                        cnt_q  <= shamt;
                    end else if (go_mul) begin
                        work_q  <= B;
                        mcand_q <= A;
                        hi_q    <= '0;
                        cnt_q   <= WIDTH_C;
                    end else begin
                        done <= 1'b1;
                        D    <= alu_d;
                        D_hi <= '0;
                        C    <= alu_c;
                        Z    <= (alu_d == '0) && !alu_rsv;
                        N    <= alu_d[MSB];
                        V    <= alu_v;
                    end
                end
                SHIFT: begin
                    work_q <= sh_next;
                    cnt_q  <= cnt_q - CW'(1);
                    if (last_step) begin
                        done <= 1'b1;
                        D    <= sh_next;
                        D_hi <= '0;
                        C    <= sh_out;
                        Z    <= (sh_next == '0);
                        N    <= sh_next[MSB];
                        V    <= 1'b0;
                    end
                end
                MUL: begin
                    hi_q   <= mul_hi;
                    work_q <= mul_lo;
                    cnt_q  <= cnt_q - CW'(1);
                    if (last_step) begin
                        done <= 1'b1;
                        D    <= mul_lo;
                        D_hi <= mul_hi;
                        C    <= (mul_hi != '0);
                        Z    <= (mul_lo == '0);
                        N    <= mul_lo[MSB];
                        V    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a vector table at WIDTH=8 plus hand-written
// back-to-back, ignored-start, reset-abort and WIDTH=16 sequences.
module tb_seq_alu;

    typedef struct {
        logic [3:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        int         lat;
        logic [7:0] d;
        logic [7:0] d_hi;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] A, B;
    logic [3:0] S;
    logic       Cin;
    logic       busy, done;
    logic [7:0] D, D_hi;
    logic       C, Z, N, V;

    logic        start16;
    logic [15:0] A16, B16;
    logic [3:0]  S16;
    logic        Cin16;
    logic        busy16, done16;
    logic [15:0] D16, D_hi16;
    logic        C16, Z16, N16, V16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .S(S), .Cin(Cin),
        .busy(busy), .done(done), .D(D), .D_hi(D_hi), .C(C), .Z(Z), .N(N), .V(V)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .A(A16), .B(B16), .S(S16), .Cin(Cin16),
        .busy(busy16), .done(done16), .D(D16), .D_hi(D_hi16), .C(C16), .Z(Z16), .N(N16), .V(V16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; issues v there and returns at the falling edge
    // of the done cycle. poke_cyc > 0 pulses a conflicting start in that cycle.
    task automatic run_vec(input vec_t v, input int poke_cyc, input string tag);
        int cyc;
        bit busy_bad;
        S = v.s; A = v.a; B = v.b; Cin = v.cin; start = 1'b1;
        cyc = 0;
        busy_bad = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == poke_cyc) begin
                start = 1'b1; S = 4'b0000; A = 8'h12; B = 8'h34; Cin = 1'b0;
            end
            if (done === 1'b1) break;
            if (busy !== (v.lat > 1)) busy_bad = 1'b1;
            if (cyc >= 40) break;
        end
        if (busy !== 1'b0) busy_bad = 1'b1;
        check({tag, ".latency"}, cyc, v.lat);
        check({tag, ".busy_ok"}, {31'd0, ~busy_bad}, 1);
        check({tag, ".D"},    D,    v.d);
        check({tag, ".D_hi"}, D_hi, v.d_hi);
        check({tag, ".C"},    C,    v.c);
        check({tag, ".Z"},    Z,    v.z);
        check({tag, ".N"},    N,    v.n);
        check({tag, ".V"},    V,    v.v);
    endtask

    vec_t vecs[17];
    vec_t tmp;
    bit   saw_done;

    initial begin
        //            s        a      b      cin  lat d      d_hi   c     z     n     v
        vecs[0]  = '{4'b0000, 8'hF0, 8'h20, 1'b0, 1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}; // ADD carry
        vecs[1]  = '{4'b0100, 8'h81, 8'h03, 1'b0, 4, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // SHL 3
        vecs[2]  = '{4'b1010, 8'h80, 8'h0A, 1'b0, 9, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}; // ASR clamp
        vecs[3]  = '{4'b0101, 8'h5A, 8'h00, 1'b0, 1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // SHR 0
        vecs[4]  = '{4'b1011, 8'hFF, 8'hFF, 1'b0, 9, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0}; // MUL max
        vecs[5]  = '{4'b1101, 8'hAA, 8'h55, 1'b0, 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // reserved
        vecs[6]  = '{4'b0000, 8'h7F, 8'h01, 1'b0, 1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1}; // ADD ovf
        vecs[7]  = '{4'b0010, 8'hF0, 8'h3C, 1'b0, 1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // AND
        vecs[8]  = '{4'b0011, 8'h0F, 8'hF0, 1'b0, 1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // OR
        vecs[9]  = '{4'b0110, 8'hAA, 8'hAA, 1'b0, 1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // XOR zero
        vecs[10] = '{4'b0111, 8'h0F, 8'h00, 1'b0, 1, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // NOT
        vecs[11] = '{4'b1001, 8'h10, 8'h01, 1'b0, 1, 8'h0E, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}; // SBC Cin=0
        vecs[12] = '{4'b0101, 8'h81, 8'h01, 1'b0, 2, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}; // SHR 1
        vecs[13] = '{4'b0100, 8'h01, 8'h08, 1'b0, 9, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}; // SHL n=WIDTH
        vecs[14] = '{4'b1011, 8'h0D, 8'h0B, 1'b0, 9, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // MUL small
        vecs[15] = '{4'b1010, 8'hC3, 8'h02, 1'b0, 3, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}; // ASR 2
        vecs[16] = '{4'b1011, 8'h37, 8'h00, 1'b0, 9, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // MUL by 0

        reset = 1'b1; start = 1'b0; A = '0; B = '0; S = '0; Cin = 1'b0;
        start16 = 1'b0; A16 = '0; B16 = '0; S16 = '0; Cin16 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.D", D, 0);
        check("reset.D_hi", D_hi, 0);
        check("reset.flags", {C, Z, N, V}, 0);
        check("reset16.D", D16, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], 0, $sformatf("v%0d", i));
            @(negedge clk);
            check($sformatf("v%0d.done_pulse", i), done, 0);
            check($sformatf("v%0d.D_hold", i), D, vecs[i].d);
        end

        // Back-to-back issue in each done cycle.
        tmp = '{4'b0001, 8'h05, 8'h07, 1'b0, 1, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        run_vec(tmp, 0, "b2b_sub1");
        tmp = '{4'b0001, 8'h80, 8'h01, 1'b0, 1, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        run_vec(tmp, 0, "b2b_sub2");
        tmp = '{4'b1000, 8'hFF, 8'h00, 1'b1, 1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        run_vec(tmp, 0, "b2b_adc");
        @(negedge clk);

        // A start pulsed mid-MUL must be ignored.
        tmp = '{4'b1011, 8'hFF, 8'hFF, 1'b0, 9, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0};
        run_vec(tmp, 4, "mul_poke");
        @(negedge clk);
        check("mul_poke.no_extra_done", done, 0);
        check("mul_poke.D_hold", D, 8'h01);

        // Reset during cycle 5 of a MUL aborts it without a done.
        S = 4'b1011; A = 8'hFF; B = 8'hFF; Cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort.busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.D", D, 0);
        check("abort.D_hi", D_hi, 0);
        check("abort.flags", {C, Z, N, V}, 0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort.no_done", {31'd0, saw_done}, 0);
        tmp = '{4'b0000, 8'h01, 8'h01, 1'b0, 1, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        run_vec(tmp, 0, "post_reset_add");
        @(negedge clk);

        // Same ADD at WIDTH=16 does not overflow.
        S16 = 4'b0000; A16 = 16'h007F; B16 = 16'h0001; Cin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check("w16.done", done16, 1);
        check("w16.busy", busy16, 0);
        check("w16.D", D16, 16'h0080);
        check("w16.D_hi", D_hi16, 0);
        check("w16.flags", {C16, Z16, N16, V16}, 0);
        @(negedge clk);
        check("w16.done_pulse", done16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
